// File: rtl/spi_ram_arbiter_pkg.sv
// Shared types and constants for the SPI-RAM command-port arbiter.
package spi_ram_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_CMD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RCMD,
        WAIT_RD,
        RESP
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    function automatic logic [ADDR_W+1:0] ram_cmd(input logic [1:0] op, input logic [DATA_W-1:0] payload);
        return {op, payload};
    endfunction

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Requester-side and RAM-side signals of the arbiter; slave = arbiter, master = its environment.
interface spi_ram_arbiter_if #(parameter int NUM_REQ = 2);
    import spi_ram_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [ADDR_W+1:0]         ram_din;
    logic                      ram_rx_valid;
    logic [DATA_W-1:0]         ram_dout;
    logic                      ram_tx_valid;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_dout, ram_tx_valid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_dout, ram_tx_valid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid
    );

endinterface

// File: rtl/spi_ram_arbiter_rr.sv
// Round-robin grant: first active request at or after the rotating pointer.
// Latency: grant is combinational; pointer moves past the winner on the clock after advance.
// Backpressure: none; losers simply keep requesting and see no grant.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr;

    // Walk offsets from farthest to nearest so the nearest active request wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares the SPI-RAM command port between NUM_REQ requesters, expanding each request into two RAM beats.
// Latency: write beats T+1/T+2, rsp T+3; read rsp one cycle after ram_tx_valid (T+4 with a prompt RAM).
// Backpressure: one transaction in flight; req_ready only in IDLE. Read timeout under SPI_RAM_ARB_TIMEOUT_EN.
module spi_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int RD_TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_ram_arbiter_if.slave    bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || RD_TIMEOUT < 1) begin : g_bad_param
        $error("spi_ram_arbiter: NUM_REQ must be 2..4 and RD_TIMEOUT at least 1");
    end

    state_t             state;
    txn_t               txn;
    logic [NUM_REQ-1:0] owner;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               accept;

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic [ADDR_W+1:0]  ram_din_q;
    logic               ram_rx_valid_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept        = rst_n && (state == IDLE) && (|grant);
    assign bus.req_ready = accept ? grant : '0;

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.ram_din      = ram_din_q;
    assign bus.ram_rx_valid = ram_rx_valid_q;

`ifdef SPI_RAM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(RD_TIMEOUT + 1) > 3) ? $clog2(RD_TIMEOUT + 1) : 3;
    logic [CNT_W-1:0] rd_cnt;
    logic             rsp_err_q;
    logic             rd_expired;
    assign rd_expired  = (rd_cnt == CNT_W'(RD_TIMEOUT - 1));
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // RAM beat outputs are loaded on the edge entering ADDR/DATA/RCMD so they line up with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            txn            <= '0;
            owner          <= '0;
            rsp_valid_q    <= '0;
            rsp_rdata_q    <= '0;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
            rd_cnt         <= '0;
            rsp_err_q      <= 1'b0;
`endif
        end else begin
            rsp_valid_q    <= '0;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner          <= grant;
                        txn            <= '{we:    bus.req_we[grant_idx],
                                            addr:  bus.req_addr[grant_idx*ADDR_W +: ADDR_W],
                                            wdata: bus.req_wdata[grant_idx*DATA_W +: DATA_W]};
                        ram_rx_valid_q <= 1'b1;
                        ram_din_q      <= ram_cmd(bus.req_we[grant_idx] ? OP_WR_ADDR : OP_RD_ADDR,
                                                  bus.req_addr[grant_idx*ADDR_W +: ADDR_W]);
                        state          <= ADDR;
                    end
                end
                ADDR: begin
                    ram_rx_valid_q <= 1'b1;
                    if (txn.we) begin
                        ram_din_q <= ram_cmd(OP_WR_DATA, txn.wdata);
                        state     <= DATA;
                    end else begin
                        ram_din_q <= ram_cmd(OP_RD_CMD, '0);
                        state     <= RCMD;
                    end
                end
                DATA: begin
                    rsp_valid_q <= owner;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
                    rsp_err_q   <= 1'b0;
`endif
                    state       <= RESP;
                end
                RCMD: begin
`ifdef SPI_RAM_ARB_TIMEOUT_EN
                    rd_cnt <= '0;
`endif
                    state  <= WAIT_RD;
                end
                WAIT_RD: begin
                    if (bus.ram_tx_valid) begin
                        rsp_rdata_q <= bus.ram_dout;
                        rsp_valid_q <= owner;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state       <= RESP;
                    end
`ifdef SPI_RAM_ARB_TIMEOUT_EN
                    else if (rd_expired) begin
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= owner;
                        rsp_err_q   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural SPI-RAM and a response scoreboard.
module tb_spi_ram_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int RD_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_ram_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

    spi_ram_arbiter #(.NUM_REQ(NUM_REQ), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: command decode on rx_valid, tx_valid held until the next command.
    logic [7:0] ram_mem [256];
    logic [7:0] ram_wa, ram_ra;
    bit         ram_mute = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.ram_tx_valid <= 1'b0;
            bus.ram_dout     <= 8'h00;
            ram_wa           <= 8'h00;
            ram_ra           <= 8'h00;
        end else if (bus.ram_rx_valid) begin
            bus.ram_tx_valid <= 1'b0;
            case (bus.ram_din[9:8])
                2'b00: ram_wa <= bus.ram_din[7:0];
                2'b01: ram_mem[ram_wa] <= bus.ram_din[7:0];
                2'b10: ram_ra <= bus.ram_din[7:0];
                default: begin
                    if (!ram_mute) begin
                        bus.ram_dout     <= ram_mem[ram_ra];
                        bus.ram_tx_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    typedef struct {
        int         owner;
        logic [7:0] rdata;
        logic       err;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_mem [256];
    logic [7:0] exp_rdata = 8'h00;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] cur_a [NUM_REQ];
    logic [7:0] cur_d [NUM_REQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if ((|bus.rsp_valid) === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", 32'(bus.rsp_valid), 32'(1 << e.owner));
                chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                chk("rsp_err",   32'(bus.rsp_err),   32'(e.err));
                chk("rsp_cycle", cyc, e.due);
            end
        end
    end

    task automatic drive_req(input int r, input bit we, input logic [7:0] a, input logic [7:0] d);
        bus.req_valid[r]        = 1'b1;
        bus.req_we[r]           = we;
        bus.req_addr[r*8 +: 8]  = a;
        bus.req_wdata[r*8 +: 8] = d;
        cur_a[r] = a;
        cur_d[r] = d;
    endtask

    task automatic push_exp(input int r, input bit we, input logic [7:0] a, input logic [7:0] d, input int t);
        exp_t e;
        e.owner = r;
        e.err   = 1'b0;
        if (we) begin
            exp_mem[a] = d;
            e.rdata    = exp_rdata;
            e.due      = t + 3;
        end else begin
            exp_rdata = exp_mem[a];
            e.rdata   = exp_rdata;
            e.due     = t + 4;
        end
        sb.push_back(e);
    endtask

    task automatic wait_grant(output int t);
        int n = 0;
        while ((|bus.req_ready) !== 1'b1 && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        chk("grant_seen", 32'(|bus.req_ready), 32'h1);
        t = cyc;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk); #2;
            n++;
        end
        chk({tag, "_drained"}, sb.size(), 0);
    endtask

    task automatic txn(input string tag, input int r, input bit we, input logic [7:0] a, input logic [7:0] d);
        int t;
        logic [9:0] b1, b2;
        @(negedge clk);
        drive_req(r, we, a, d);
        #1;
        wait_grant(t);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << r));
        push_exp(r, we, a, d, t);
        b1 = we ? {2'b00, a} : {2'b10, a};
        b2 = we ? {2'b01, d} : 10'h300;
        @(negedge clk);
        bus.req_valid[r] = 1'b0;
        #1;
        chk({tag, "_beat1"}, {bus.ram_rx_valid, bus.ram_din}, {1'b1, b1});
        @(negedge clk); #1;
        chk({tag, "_beat2"}, {bus.ram_rx_valid, bus.ram_din}, {1'b1, b2});
        drain(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t0, t1, t2, r;
        exp_t e;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst_n = 1'b0;

        // Reset state, with requests present to prove req_ready is forced low.
        repeat (2) @(negedge clk);
        bus.req_valid = '1;
        #1;
        chk("rst_req_ready",    32'(bus.req_ready),    32'h0);
        chk("rst_rsp_valid",    32'(bus.rsp_valid),    32'h0);
        chk("rst_rsp_rdata",    32'(bus.rsp_rdata),    32'h0);
        chk("rst_rsp_err",      32'(bus.rsp_err),      32'h0);
        chk("rst_ram_din",      32'(bus.ram_din),      32'h0);
        chk("rst_ram_rx_valid", 32'(bus.ram_rx_valid), 32'h0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        txn("wr", 0, 1'b1, 8'h3C, 8'hA5);
        txn("rd", 1, 1'b0, 8'h3C, 8'h00);

        // Contention from reset: both hold writes, grants must alternate 0,1,0,1.
        @(negedge clk);
        rst_n = 1'b0;
        exp_rdata = 8'h00;
        @(negedge clk);
        drive_req(0, 1'b1, 8'h40, 8'h90);
        drive_req(1, 1'b1, 8'h41, 8'h91);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(t);
            chk($sformatf("cont%0d_grant", k), 32'(bus.req_ready), (k % 2) ? 32'h2 : 32'h1);
            chk($sformatf("cont%0d_quiet", k), 32'(bus.ram_rx_valid), 32'h0);
            r = (bus.req_ready[1] === 1'b1) ? 1 : 0;
            push_exp(r, 1'b1, cur_a[r], cur_d[r], t);
            @(negedge clk); #1;
            drive_req(r, 1'b1, 8'(8'h40 + k + 2), 8'(8'h90 + k + 2));
        end
        bus.req_valid = '0;
        drain("cont");
        txn("rb41", 0, 1'b0, 8'h41, 8'h00);
        txn("rb43", 1, 1'b0, 8'h43, 8'h00);

        // Fairness: requester 0 keeps requesting, requester 1 asks once mid-transaction.
        @(negedge clk);
        drive_req(0, 1'b1, 8'h50, 8'hB0);
        #1;
        wait_grant(t0);
        chk("fair_first", 32'(bus.req_ready), 32'h1);
        push_exp(0, 1'b1, 8'h50, 8'hB0, t0);
        @(negedge clk); #1;
        drive_req(0, 1'b1, 8'h51, 8'hB1);
        drive_req(1, 1'b0, 8'h3C, 8'h00);
        wait_grant(t1);
        chk("fair_r1_grant", 32'(bus.req_ready), 32'h2);
        chk("fair_r1_cycle", t1, t0 + 4);
        push_exp(1, 1'b0, 8'h3C, 8'h00, t1);
        @(negedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_grant(t2);
        chk("fair_r0_grant", 32'(bus.req_ready), 32'h1);
        chk("fair_r0_cycle", t2, t1 + 5);
        push_exp(0, 1'b1, 8'h51, 8'hB1, t2);
        @(negedge clk); #1;
        bus.req_valid = '0;
        drain("fair");

        // Reset while requester 0's read sits in WAIT_RD.
        @(negedge clk);
        drive_req(0, 1'b0, 8'h41, 8'h00);
        #1;
        wait_grant(t);
        chk("mid_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk); #1;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_rdata = 8'h00;
        drive_req(0, 1'b1, 8'h60, 8'hC0);
        drive_req(1, 1'b1, 8'h61, 8'hC1);
        @(negedge clk); #1;
        chk("mid_rsp_valid", 32'(bus.rsp_valid),    32'h0);
        chk("mid_ram_rx",    32'(bus.ram_rx_valid), 32'h0);
        chk("mid_req_ready", 32'(bus.req_ready),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        wait_grant(t);
        chk("mid_next_grant", 32'(bus.req_ready), 32'h1);
        push_exp(0, 1'b1, 8'h60, 8'hC0, t);
        @(negedge clk); #1;
        bus.req_valid = '0;
        drain("mid");

`ifdef SPI_RAM_ARB_TIMEOUT_EN
        // RAM never answers: error response RD_TIMEOUT cycles after entering WAIT_RD.
        ram_mute = 1'b1;
        @(negedge clk);
        drive_req(1, 1'b0, 8'h3C, 8'h00);
        #1;
        wait_grant(t);
        chk("to_grant", 32'(bus.req_ready), 32'h2);
        e.owner = 1;
        e.rdata = 8'h00;
        e.err   = 1'b1;
        e.due   = t + 3 + RD_TIMEOUT;
        exp_rdata = 8'h00;
        sb.push_back(e);
        @(negedge clk); #1;
        bus.req_valid = '0;
        drain("to");
        ram_mute = 1'b0;
`endif

        txn("rd50", 1, 1'b0, 8'h50, 8'h00);
        txn("wr_hold", 0, 1'b1, 8'h70, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
